// File: rtl/soi_event_capture.sv
// Records timestamped changes of a monitored signal into a first-word-fall-through event FIFO.
// Latency: an event seen in cycle N is presented at the head in cycle N+1 when the FIFO is empty.
// Backpressure: evt_valid/evt_ready handshake; events arriving while full with no pop are dropped and counted.
module soi_event_capture #(
    parameter int SOI_W = 8,
    parameter int TS_W  = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SOI_W-1:0]       soi_in,
    input  logic                   arm,
    input  logic                   clear,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [SOI_W-1:0]       evt_data,
    output logic [TS_W-1:0]        evt_ts,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [SOI_W-1:0] data;
        logic [TS_W-1:0]  ts;
    } evt_t;

    evt_t             mem [DEPTH];
    evt_t             head;
    logic [TS_W-1:0]  ts;
    logic [SOI_W-1:0] soi_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             evt;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign evt  = arm && (soi_in != soi_q);
    assign full = (level == LVL_W'(DEPTH));
    assign pop  = evt_valid && evt_ready;
    // A pop in the same cycle frees the slot the new event needs, so a full FIFO still accepts it.
    assign push = evt && (!full || pop);
    assign drop = evt && full && !pop;

    // soi_q tracks the input even while disarmed or clearing, so re-arming never sees a stale sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts    <= '0;
            soi_q <= '0;
        end else begin
            soi_q <= soi_in;
            ts    <= clear ? '0 : ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= {soi_in, ts};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (level != '0);
    assign evt_data  = evt_valid ? head.data : '0;
    assign evt_ts    = evt_valid ? head.ts : '0;

endmodule

// File: tb/tb_soi_event_capture.sv
// Bench for soi_event_capture: a default instance and a narrow (TS_W=4, CNT_W=2) instance share stimulus.
module tb_soi_event_capture;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] soi_in = 8'h00;
    logic       arm = 1'b0;
    logic       clear = 1'b0;
    logic       evt_ready = 1'b0;

    logic       d0_valid, d1_valid;
    logic [7:0] d0_data, d1_data;
    logic [15:0] d0_ts;
    logic [3:0] d1_ts;
    logic [3:0] d0_level, d1_level;
    logic       d0_ovf, d1_ovf;
    logic [7:0] d0_drop;
    logic [1:0] d1_drop;

    soi_event_capture u_dut0 (
        .clk(clk), .rst_n(rst_n), .soi_in(soi_in), .arm(arm), .clear(clear),
        .evt_valid(d0_valid), .evt_ready(evt_ready), .evt_data(d0_data), .evt_ts(d0_ts),
        .level(d0_level), .overflow(d0_ovf), .drop_cnt(d0_drop)
    );

    soi_event_capture #(.TS_W(4), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .soi_in(soi_in), .arm(arm), .clear(clear),
        .evt_valid(d1_valid), .evt_ready(evt_ready), .evt_data(d1_data), .evt_ts(d1_ts),
        .level(d1_level), .overflow(d1_ovf), .drop_cnt(d1_drop)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of (value, absolute cycle time) plus sticky flags.
    typedef struct {
        logic [7:0] data;
        int         ts;
    } ev_t;

    ev_t        q[$];
    int         m_ts = 0;
    int         m_drop = 0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_soi_q = 8'h00;

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        q.delete();
        m_ts = 0;
        m_drop = 0;
        m_ovf = 1'b0;
        m_soi_q = 8'h00;
    endtask

    // Advance the model by one cycle using the current inputs, then clock the DUTs.
    task automatic step();
        bit ev;
        bit pop;
        ev  = arm && (soi_in != m_soi_q);
        pop = evt_ready && (q.size() > 0);
        if (clear) begin
            q.delete();
            m_ts = 0;
            m_ovf = 1'b0;
            m_drop = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (ev) begin
                if (q.size() < DEPTH) q.push_back('{soi_in, m_ts});
                else begin
                    m_ovf = 1'b1;
                    m_drop++;
                end
            end
            m_ts++;
        end
        m_soi_q = soi_in;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({d0_valid, d0_level, d0_data, d0_ts, d0_ovf, d0_drop} !== 38'd0) begin
            errors++;
            $display("FAIL reset_d0: got v=%0d lvl=%0d d=%h ts=%h ovf=%0d drop=%0d want all 0",
                     d0_valid, d0_level, d0_data, d0_ts, d0_ovf, d0_drop);
        end
        checks++;
        if ({d1_valid, d1_level, d1_data, d1_ts, d1_ovf, d1_drop} !== 20'd0) begin
            errors++;
            $display("FAIL reset_d1: got v=%0d lvl=%0d d=%h ts=%h ovf=%0d drop=%0d want all 0",
                     d1_valid, d1_level, d1_data, d1_ts, d1_ovf, d1_drop);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_first_event();
        arm = 1'b1;
        soi_in = 8'h00;
        repeat (3) step();
        soi_in = 8'h5A;
        step();
        checks++;
        if ({d0_valid, d0_data, d0_ts, d0_level} !== {1'b1, 8'h5A, 16'd3, 4'd1}) begin
            errors++;
            $display("FAIL first_event: got v=%0d d=%h ts=%0d lvl=%0d want v=1 d=5a ts=3 lvl=1",
                     d0_valid, d0_data, d0_ts, d0_level);
        end
        checks++;
        if (d1_ts !== 4'd3) begin
            errors++;
            $display("FAIL first_event_ts4: got %0d want 3", d1_ts);
        end
    endtask

    task automatic test_overflow();
        clear = 1'b1;
        step();
        clear = 1'b0;
        evt_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            soi_in = 8'h10 + 8'(i);
            step();
        end
        checks++;
        if ({d0_level, d0_ovf, d0_drop, d0_data} !== {4'd8, 1'b1, 8'd2, 8'h10}) begin
            errors++;
            $display("FAIL overflow_d0: got lvl=%0d ovf=%0d drop=%0d head=%h want lvl=8 ovf=1 drop=2 head=10",
                     d0_level, d0_ovf, d0_drop, d0_data);
        end
        checks++;
        if ({d1_level, d1_ovf, d1_drop} !== {4'd8, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL overflow_d1: got lvl=%0d ovf=%0d drop=%0d want lvl=8 ovf=1 drop=2",
                     d1_level, d1_ovf, d1_drop);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_d;
        evt_ready = 1'b1;
        soi_in = 8'h77;
        step();
        evt_ready = 1'b0;
        checks++;
        if ({d0_level, d0_drop, d0_data} !== {4'd8, 8'd2, 8'h11}) begin
            errors++;
            $display("FAIL full_push_pop: got lvl=%0d drop=%0d head=%h want lvl=8 drop=2 head=11",
                     d0_level, d0_drop, d0_data);
        end
        arm = 1'b0;
        evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_d = (k < 7) ? 8'h11 + 8'(k) : 8'h77;
            checks++;
            if (d0_data !== exp_d || d0_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_order[%0d]: got v=%0d d=%h want v=1 d=%h", k, d0_valid, d0_data, exp_d);
            end
            step();
        end
        evt_ready = 1'b0;
        checks++;
        if ({d0_valid, d0_level, d0_data, d0_ts} !== 29'd0) begin
            errors++;
            $display("FAIL drain_empty: got v=%0d lvl=%0d d=%h ts=%h want all 0", d0_valid, d0_level, d0_data, d0_ts);
        end
    endtask

    task automatic test_disarmed();
        arm = 1'b0;
        evt_ready = 1'b0;
        repeat (5) begin
            soi_in = soi_in ^ 8'hFF;
            step();
        end
        checks++;
        if (d0_level !== 4'd0) begin
            errors++;
            $display("FAIL disarmed_level: got %0d want 0", d0_level);
        end
        arm = 1'b1;
        repeat (3) step();
        checks++;
        if ({d0_valid, d0_level, d1_level} !== 9'd0) begin
            errors++;
            $display("FAIL rearm_no_event: got v=%0d lvl0=%0d lvl1=%0d want 0", d0_valid, d0_level, d1_level);
        end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        arm = 1'b1;
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            soi_in = 8'h20 + 8'(i);
            step();
        end
        arm = 1'b0;
        evt_ready = 1'b1;
        repeat (5) step();
        checks++;
        if ({d0_level, d0_ovf} !== {4'd3, 1'b1}) begin
            errors++;
            $display("FAIL clear_setup: got lvl=%0d ovf=%0d want lvl=3 ovf=1", d0_level, d0_ovf);
        end
        clear = 1'b1;
        arm = 1'b1;
        soi_in = 8'hC3;
        step();
        clear = 1'b0;
        evt_ready = 1'b0;
        checks++;
        if ({d0_valid, d0_level, d0_ovf, d0_drop, d0_data, d0_ts} !== 38'd0) begin
            errors++;
            $display("FAIL clear_state: got v=%0d lvl=%0d ovf=%0d drop=%0d d=%h ts=%h want all 0",
                     d0_valid, d0_level, d0_ovf, d0_drop, d0_data, d0_ts);
        end
        soi_in = 8'h3C;
        step();
        checks++;
        if ({d0_valid, d0_data, d0_ts, d1_ts} !== {1'b1, 8'h3C, 16'd0, 4'd0}) begin
            errors++;
            $display("FAIL clear_ts_restart: got v=%0d d=%h ts0=%0d ts1=%0d want v=1 d=3c ts=0",
                     d0_valid, d0_data, d0_ts, d1_ts);
        end
    endtask

    task automatic test_ts_wrap_and_async_reset();
        clear = 1'b1;
        step();
        clear = 1'b0;
        arm = 1'b0;
        repeat (15) step();
        arm = 1'b1;
        soi_in = 8'h01;
        step();
        soi_in = 8'h02;
        step();
        checks++;
        if ({d1_ts, d0_ts} !== {4'd15, 16'd15}) begin
            errors++;
            $display("FAIL ts_wrap_first: got ts1=%0d ts0=%0d want 15 15", d1_ts, d0_ts);
        end
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        checks++;
        if ({d1_ts, d0_ts} !== {4'd0, 16'd16}) begin
            errors++;
            $display("FAIL ts_wrap_second: got ts1=%0d ts0=%0d want 0 16", d1_ts, d0_ts);
        end
        soi_in = 8'h03;
        step();
        checks++;
        if (d0_level !== 4'd2) begin
            errors++;
            $display("FAIL pre_reset_level: got %0d want 2", d0_level);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({d0_valid, d1_valid, d0_level, d1_level, d0_data, d0_ts} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset: got v0=%0d v1=%0d lvl0=%0d lvl1=%0d d=%h ts=%h want all 0",
                     d0_valid, d1_valid, d0_level, d1_level, d0_data, d0_ts);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        soi_in = 8'h44;
        step();
        checks++;
        if ({d0_valid, d0_data, d0_ts, d1_ts, d0_level} !== {1'b1, 8'h44, 16'd0, 4'd0, 4'd1}) begin
            errors++;
            $display("FAIL post_reset_event: got v=%0d d=%h ts0=%0d ts1=%0d lvl=%0d want v=1 d=44 ts=0 lvl=1",
                     d0_valid, d0_data, d0_ts, d1_ts, d0_level);
        end
    endtask

    task automatic test_random();
        logic [37:0] e0;
        logic [19:0] e1;
        logic        ev_v;
        logic [7:0]  ev_d;
        int          ev_ts;
        for (int c = 0; c < 800; c++) begin
            arm       = ($urandom % 4) != 0;
            evt_ready = (c < 400) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
            soi_in    = 8'($urandom_range(0, 3));
            clear     = ($urandom % 97) == 0;
            step();
            ev_v  = q.size() != 0;
            ev_d  = ev_v ? q[0].data : 8'h00;
            ev_ts = ev_v ? q[0].ts : 0;
            e0 = {ev_v, ev_d, 16'(ev_ts), 4'(q.size()), m_ovf, 8'((m_drop > 255) ? 255 : m_drop)};
            e1 = {ev_v, ev_d, 4'(ev_ts), 4'(q.size()), m_ovf, 2'((m_drop > 3) ? 3 : m_drop)};
            checks++;
            if ({d0_valid, d0_data, d0_ts, d0_level, d0_ovf, d0_drop} !== e0) begin
                errors++;
                $display("FAIL rand_d0 cycle %0d: got %h want %h", c,
                         {d0_valid, d0_data, d0_ts, d0_level, d0_ovf, d0_drop}, e0);
            end
            checks++;
            if ({d1_valid, d1_data, d1_ts, d1_level, d1_ovf, d1_drop} !== e1) begin
                errors++;
                $display("FAIL rand_d1 cycle %0d: got %h want %h", c,
                         {d1_valid, d1_data, d1_ts, d1_level, d1_ovf, d1_drop}, e1);
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_event();
        test_overflow();
        test_full_push_pop();
        test_disarmed();
        test_clear();
        test_ts_wrap_and_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soi_event_capture.md
SOI_EVENT_CAPTURE -- requirements
Module: soi_event_capture

Interface
REQ-001 SHALL have parameter SOI_W, default 8, width of the signal of interest.
REQ-002 SHALL have parameter TS_W, default 16, timestamp width.
REQ-003 SHALL have parameter DEPTH, default 8, event FIFO entries; power of two, >= 2.
REQ-004 SHALL have parameter CNT_W, default 8, drop counter width.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port soi_in  input  SOI_W  monitored signal of interest, synchronous to clk.
REQ-008 SHALL have port arm  input  1  level; 1 = record changes of soi_in.
REQ-009 SHALL have port clear  input  1  synchronous flush pulse.
REQ-010 SHALL have port evt_valid  output  1  head event available.
REQ-011 SHALL have port evt_ready  input  1  downstream reader accepts head event.
REQ-012 SHALL have port evt_data  output  SOI_W  soi_in value of head event.
REQ-013 SHALL have port evt_ts  output  TS_W  timestamp of head event.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  number of queued events.
REQ-015 SHALL have port overflow  output  1  sticky: at least one event dropped.
REQ-016 SHALL have port drop_cnt  output  CNT_W  dropped-event count.

Function
REQ-017 SHALL keep free-running counter ts, +1 every cycle, wrapping 2^TS_W-1 -> 0.
REQ-018 SHALL register soi_q <= soi_in every cycle regardless of arm.
REQ-019 SHALL raise internal event in cycle N when arm=1 and soi_in != soi_q; record {soi_in, ts} of cycle N.
REQ-020 SHALL hold no event when arm=0; changes while disarmed are not recorded, and the first armed cycle compares against soi_q (last sample).
REQ-021 SHALL store events in a FIFO of DEPTH entries, first-word-fall-through: evt_valid = (level != 0), evt_data/evt_ts = oldest entry.
REQ-022 SHALL make an event from cycle N visible at evt_valid in cycle N+1 if FIFO was empty (latency 1).
REQ-023 SHALL pop when evt_valid && evt_ready; evt_ready with evt_valid=0 has no effect.
REQ-024 SHALL keep evt_data/evt_ts stable while evt_valid=1 and evt_ready=0.
REQ-025 SHALL push when event and (level < DEPTH or pop in same cycle); simultaneous push+pop when full keeps level = DEPTH.
REQ-026 SHALL drop event when level = DEPTH and no pop: overflow <= 1, drop_cnt +1 saturating at 2^CNT_W-1.
REQ-027 SHALL update level as +1 push only, -1 pop only, unchanged for both or neither.
REQ-028 SHALL wrap read/write pointers modulo DEPTH without loss or duplication.
REQ-029 SHALL on clear=1: empty FIFO, level=0, ts=0, overflow=0, drop_cnt=0 next cycle; clear overrides push and pop that cycle; soi_q still updates.
REQ-030 SHALL drive evt_data/evt_ts to 0 when evt_valid=0.

Reset
REQ-031 SHALL on rst_n=0 immediately force: evt_valid=0, level=0, evt_data=0, evt_ts=0, overflow=0, drop_cnt=0, ts=0, soi_q=0, pointers=0.
REQ-032 SHALL lose all queued events on reset mid-operation; first ts after release is 0.
REQ-033 SHALL resume normal operation on first rising clk edge after rst_n deasserts.

Verification
REQ-034 Reset release, arm=1, soi_in 0x00 -> 0x5A at ts=3 -> evt_valid=1 next cycle, evt_data=0x5A, evt_ts=3, level=1.
REQ-035 arm=1, evt_ready=0, soi_in changes on 10 consecutive cycles -> level saturates at 8, overflow=1, drop_cnt=2, head = first change.
REQ-036 FIFO full, evt_ready=1 and new change in same cycle -> level stays 8, no drop, drop_cnt unchanged, order preserved.
REQ-037 arm=0, soi_in toggles 5 times -> level=0; arm=1 with soi_in unchanged -> no event.
REQ-038 3 events queued, overflow=1, clear pulse with simultaneous change and evt_ready=1 -> next cycle level=0, evt_valid=0, overflow=0, drop_cnt=0, ts=0.
REQ-039 TS_W=4, change at ts=15 and next cycle -> evt_ts 15 then 0; rst_n pulsed low with 2 events queued -> evt_valid=0 asynchronously.
